// File: rtl/cbrt_arbiter_pkg.sv
// Shared types and defaults for the cubic-root arbiter slice.
// Holds the FSM state encoding plus the datapath width and default watchdog limit.
package cbrt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_e;

  localparam int CBRT_DATA_W      = 16;
  localparam int CBRT_TIMEOUT_CYC = 255;

endpackage

// File: rtl/cbrt_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit searching from ptr+1 with wrap.
// Zero latency; grant is all-zero when no request is pending.
module rr_picker
  import cbrt_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (gnt == '0 && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cbrt_arbiter.sv
// Round-robin front end sharing one cubic_root datapath; grant one cycle after req seen in IDLE.
// Requests wait while arb_busy; CBRT_ARB_TIMEOUT_EN adds a watchdog that answers with res_err.
module cbrt_arbiter
  import cbrt_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = CBRT_DATA_W
`ifdef CBRT_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = CBRT_TIMEOUT_CYC
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        res_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic                      res_err,
  output logic                      arb_busy,
  output logic                      cbrt_start,
  output logic [DATA_W-1:0]         cbrt_x,
  input  logic [1:0]                cbrt_busy,
  input  logic [DATA_W-1:0]         cbrt_out
);

  localparam int IW = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [IW-1:0]       id_q, id_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   cbrt_x_q, cbrt_x_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [IW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [NUM_REQ-1:0]  owner;
  logic                timeout;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_picker (
    .req(req),
    .ptr(rr_ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

`ifdef CBRT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          res_err_q, res_err_d;

  // Counter only runs while waiting on the datapath, so it restarts at zero for every job.
  always_comb begin
    tmo_d     = '0;
    res_err_d = timeout;
    if (state_q == WAIT_BUSY || state_q == WAIT_DONE) tmo_d = tmo_q + TW'(1);
  end

  assign timeout = (state_q == WAIT_BUSY || state_q == WAIT_DONE) &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign res_err = res_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= '0;
      res_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      res_err_q <= res_err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    cbrt_x_d   = cbrt_x_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: begin
        if (pick_gnt != '0) begin
          state_d  = ISSUE;
          id_d     = pick_idx;
          rr_ptr_d = pick_idx;
          cbrt_x_d = req_x[int'(pick_idx)*DATA_W +: DATA_W];
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeout) begin
          state_d    = RESP;
          res_data_d = '0;
        end else if (cbrt_busy != 2'b00) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (timeout) begin
          state_d    = RESP;
          res_data_d = '0;
        end else if (cbrt_busy == 2'b00) begin
          state_d    = RESP;
          res_data_d = cbrt_out;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      rr_ptr_q   <= IW'(NUM_REQ - 1);
      cbrt_x_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      cbrt_x_q   <= cbrt_x_d;
      res_data_q <= res_data_d;
    end
  end

  // Pulses are decoded from the registered state so they are exactly one cycle wide.
  assign owner      = NUM_REQ'(1) << id_q;
  assign gnt        = (state_q == ISSUE) ? owner : '0;
  assign res_valid  = (state_q == RESP) ? owner : '0;
  assign cbrt_start = (state_q == ISSUE);
  assign arb_busy   = (state_q != IDLE);
  assign cbrt_x     = cbrt_x_q;
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_cbrt_arbiter.sv
// Directed bench for cbrt_arbiter; the datapath side is driven by hand with known cube roots.
module tb_cbrt_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] req_x;
  logic [1:0]  gnt;
  logic [1:0]  res_valid;
  logic [15:0] res_data;
  logic        res_err;
  logic        arb_busy;
  logic        cbrt_start;
  logic [15:0] cbrt_x;
  logic [1:0]  cbrt_busy;
  logic [15:0] cbrt_out;

  int checks = 0;
  int errors = 0;

  cbrt_arbiter #(
    .NUM_REQ(2),
    .DATA_W (16)
`ifdef CBRT_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(20)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_x     (req_x),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .arb_busy  (arb_busy),
    .cbrt_start(cbrt_start),
    .cbrt_x    (cbrt_x),
    .cbrt_busy (cbrt_busy),
    .cbrt_out  (cbrt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Entered at the negedge of the ISSUE cycle; plays the datapath and checks the response.
  task automatic run_job(input logic [1:0] exp_v, input logic [15:0] x_exp,
                         input logic [15:0] result, input int lat,
                         input logic [1:0] req_in_done);
    step();
    chk("gnt_one_cycle", gnt, 2'b00);
    chk("start_one_cycle", cbrt_start, 1'b0);
    chk("busy_in_wait", arb_busy, 1'b1);
    cbrt_busy = 2'b01;
    cbrt_out  = 16'hDEAD;
    step();
    req = req_in_done;
    repeat (lat) step();
    chk("no_early_valid", res_valid, 2'b00);
    chk("x_stable_wait", cbrt_x, x_exp);
    cbrt_busy = 2'b00;
    cbrt_out  = result;
    step();
    chk("res_valid", res_valid, exp_v);
    chk("res_data", res_data, result);
    chk("res_err_clear", res_err, 1'b0);
    chk("x_stable_resp", cbrt_x, x_exp);
    cbrt_out = 16'hBEEF;
    step();
    chk("valid_one_cycle", res_valid, 2'b00);
    chk("idle_after_resp", arb_busy, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 2'b11;
    req_x     = {16'd125, 16'd8};
    cbrt_busy = 2'b00;
    cbrt_out  = 16'h0000;

    // Reset with both requests held
    step();
    step();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_start", cbrt_start, 1'b0);
    chk("rst_valid", res_valid, 2'b00);
    chk("rst_busy", arb_busy, 1'b0);
    chk("rst_x", cbrt_x, 16'h0000);
    chk("rst_data", res_data, 16'h0000);
    chk("rst_err", res_err, 1'b0);
    rst = 1'b0;

    // Both requesting: 0 first after reset, then 1, each with its own result
    step();
    chk("first_gnt", gnt, 2'b01);
    chk("first_start", cbrt_start, 1'b1);
    chk("first_x", cbrt_x, 16'd8);
    run_job(2'b01, 16'd8, 16'd2, 2, 2'b11);
    step();
    chk("second_gnt", gnt, 2'b10);
    chk("second_x", cbrt_x, 16'd125);
    run_job(2'b10, 16'd125, 16'd5, 5, 2'b11);

    // Requester 0 alone with x=27, granted again after the pointer wraps
    req   = 2'b01;
    req_x = {16'd125, 16'd27};
    step();
    chk("solo_gnt", gnt, 2'b01);
    chk("solo_start", cbrt_start, 1'b1);
    chk("solo_x", cbrt_x, 16'h001B);
    req = 2'b00;
    run_job(2'b01, 16'd27, 16'd3, 3, 2'b00);

    // Back-to-back on requester 0; requester 1 withdraws during WAIT_DONE
    req   = 2'b01;
    req_x = {16'd125, 16'd8};
    step();
    chk("b2b_gnt", gnt, 2'b01);
    req = 2'b10;
    run_job(2'b01, 16'd8, 16'd2, 2, 2'b00);
    repeat (3) begin
      step();
      chk("withdrawn_gnt", gnt, 2'b00);
      chk("withdrawn_busy", arb_busy, 1'b0);
    end

    // Reset in WAIT_DONE abandons the job, then a fresh request completes
    req   = 2'b01;
    req_x = {16'd27, 16'd125};
    step();
    chk("pre_rst_gnt", gnt, 2'b01);
    req = 2'b00;
    step();
    cbrt_busy = 2'b01;
    step();
    chk("pre_rst_busy", arb_busy, 1'b1);
    rst = 1'b1;
    step();
    chk("midrst_valid", res_valid, 2'b00);
    chk("midrst_busy", arb_busy, 1'b0);
    chk("midrst_x", cbrt_x, 16'h0000);
    chk("midrst_data", res_data, 16'h0000);
    rst       = 1'b0;
    cbrt_busy = 2'b00;
    req       = 2'b10;
    step();
    chk("post_rst_gnt", gnt, 2'b10);
    chk("post_rst_x", cbrt_x, 16'd27);
    req = 2'b00;
    run_job(2'b10, 16'd27, 16'd3, 1, 2'b00);

    // Datapath never raises busy
    req   = 2'b01;
    req_x = {16'd0, 16'd8};
    step();
    chk("stuck_gnt", gnt, 2'b01);
    req = 2'b00;
`ifdef CBRT_ARB_TIMEOUT_EN
    repeat (20) begin
      step();
      chk("tmo_no_valid", res_valid, 2'b00);
    end
    step();
    chk("tmo_valid", res_valid, 2'b01);
    chk("tmo_err", res_err, 1'b1);
    chk("tmo_data", res_data, 16'h0000);
    step();
    chk("tmo_idle", arb_busy, 1'b0);
    chk("tmo_err_clear", res_err, 1'b0);
`else
    repeat (40) begin
      step();
      chk("stuck_busy", arb_busy, 1'b1);
      chk("stuck_no_valid", res_valid, 2'b00);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("stuck_recover", arb_busy, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbrt_arbiter.md
Name: cbrt_arbiter

Overview:
- Shares one `cubic_root` datapath between NUM_REQ requesters.
- Arbitrates round-robin and launches one root computation at a time using the datapath's start/busy contract.
- Returns each 16-bit result to the requester that issued it.
- Sits between client blocks and the single `cubic_root` instance; the datapath is reset by the same rst.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 16, operand/result width; must match `cubic_root` x_bi/out.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with CBRT_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_x  in  NUM_REQ*DATA_W  per-requester operands; slice i is bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse; operand captured in that cycle.
- res_valid  out  NUM_REQ  one-hot, one-cycle result pulse to the owning requester.
- res_data  out  DATA_W  result; valid only while res_valid != 0.
- res_err  out  1  timeout flag, qualified by res_valid; constant 0 without the macro.
- arb_busy  out  1  high whenever state != IDLE.
- cbrt_start  out  1  start pulse to `cubic_root`.
- cbrt_x  out  DATA_W  operand to `cubic_root` x_bi.
- cbrt_busy  in  2  `cubic_root` busy; nonzero means computing.
- cbrt_out  in  DATA_W  `cubic_root` result.

Behaviour:
- Clocking: single clock clk. Reset is synchronous, active-high on rst.
- On reset: all outputs 0, state IDLE, rr_ptr = NUM_REQ-1 (so requester 0 has top priority first). Reset mid-operation abandons the job silently; no res_valid is issued.
- FSM:
  - IDLE: if req != 0, pick the first set bit searching from rr_ptr+1 with wrap-around. Next cycle: gnt[id]=1, cbrt_x <= req_x[id], cbrt_start=1, rr_ptr <= id, go to ISSUE.
  - ISSUE (1 cycle): cbrt_start=1 and cbrt_x held; go to WAIT_BUSY.
  - WAIT_BUSY: wait for cbrt_busy != 0, then go to WAIT_DONE.
  - WAIT_DONE: wait for cbrt_busy == 0. In that cycle res_data <= cbrt_out; go to RESP.
  - RESP (1 cycle): res_valid[id]=1; go to IDLE.
- Wait, correction to the IDLE/ISSUE split: gnt and cbrt_start rise together in the ISSUE cycle only. cbrt_start is exactly one cycle wide.
- Latency: req seen in IDLE at cycle T; gnt/cbrt_start at T+1; res_valid one cycle after the first cycle with cbrt_busy == 0 following its rise.
- cbrt_x stays stable from ISSUE through RESP.
- Handshake: a requester holds req and its req_x until it sees gnt, then may drop req or present a new operand.
  - req is sampled only in IDLE.
  - Dropping req before gnt withdraws the request; no grant is issued.
  - Requests arriving while arb_busy=1 wait. No queueing beyond each requester's own req level.
  - A requester holding req continuously is served at most once per NUM_REQ grants when others are requesting.
- Arbitration boundaries:
  - Simultaneous requests: round-robin order.
  - A single requester can be granted back to back; the minimum job spacing is set by the FSM.
  - rr_ptr wraps from NUM_REQ-1 to 0.
- Widths: no arithmetic on data. id is clog2(NUM_REQ) bits. res_data is an unmodified copy of cbrt_out.

Optional Feature:
- Macro: CBRT_ARB_TIMEOUT_EN.
- With the macro: a TIMEOUT_CYC counter runs in WAIT_BUSY and WAIT_DONE and clears on entry to ISSUE. On expiry: go to RESP with res_err=1 and res_data=0, then IDLE. The requester's res_valid still pulses.
- Without the macro: no counter, res_err tied to 0, and the FSM waits indefinitely.

Decomposition:
- Package `cbrt_pkg`:
  - state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP);
  - CBRT_DATA_W=16;
  - default TIMEOUT_CYC.
- Sub-module `rr_picker`: combinational; inputs req and ptr; outputs one-hot grant and index.

Test Plan:
- Reset with req=2'b11 held: all outputs 0, no gnt while rst=1; after release, gnt=2'b01 first.
- Requester 0 alone, x=27 (0x1B): gnt[0] and cbrt_start pulse together for one cycle; res_valid=2'b01 with res_data=3.
- Both requesting, x0=8, x1=125: grants alternate 0 then 1; results 2 then 5, each on the correct res_valid bit. A re-request from 0 is then granted only after 1.
- Requester 1 drops req while job 0 is in WAIT_DONE: no gnt[1]; arb_busy falls after RESP.
- rst asserted in WAIT_DONE: no res_valid; outputs 0 next cycle; a fresh request completes normally afterwards.
- CBRT_ARB_TIMEOUT_EN, TIMEOUT_CYC=20, cbrt_busy stuck at 0: after 20 cycles res_valid pulses with res_err=1 and res_data=0. Without the macro, arb_busy stays high.
